// File: rtl/xgmii_tx_arbiter_if.sv
// rtl/xgmii_tx_arbiter_if.sv - source-side request/data/grant bundle for xgmii_tx_arbiter
interface xgmii_tx_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]     src_req;
  logic [64*N_SRC-1:0]  src_txd;
  logic [8*N_SRC-1:0]   src_txc;
  logic [N_SRC-1:0]     src_last;
  logic [N_SRC-1:0]     src_grant;

  modport master (
    output src_req,
    output src_txd,
    output src_txc,
    output src_last,
    input  src_grant
  );

  modport slave (
    input  src_req,
    input  src_txd,
    input  src_txc,
    input  src_last,
    output src_grant
  );
endinterface

// File: rtl/xgmii_tx_arbiter.sv
// rtl/xgmii_tx_arbiter.sv - round-robin XGMII TX lane arbiter with inter-frame gap
// Optional per-grant word watchdog and abort_count port when XGMII_ARB_WATCHDOG_EN is defined.
module xgmii_tx_arbiter #(
  parameter int N_SRC      = 4,
  parameter int IFG_CYCLES = 2,
  parameter int MAX_WORDS  = 1200
) (
  input  logic                 xgmii_clk,
  input  logic                 sys_rst,
  xgmii_tx_arbiter_if.slave    src,
  output logic [63:0]          xgmii_txd,
  output logic [7:0]           xgmii_txc,
  output logic                 busy,
  output logic [31:0]          frame_count
`ifdef XGMII_ARB_WATCHDOG_EN
  ,
  output logic [15:0]          abort_count
`endif
);

  localparam int          IDX_W    = $clog2(N_SRC);
  localparam logic [63:0] IDLE_TXD = {8{8'h07}};
  localparam logic [63:0] ERR_TXD  = {8{8'hFE}};

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_IFG} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   last_winner, winner;
  logic               found;
  logic [3:0]         ifg_cnt;
  logic               grant_set, frame_done, frame_abort, wd_hit;
  logic [N_SRC-1:0]   grant_onehot;
  logic [63:0]        txd_arr [N_SRC];
  logic [7:0]         txc_arr [N_SRC];
  logic [63:0]        sel_txd;
  logic [7:0]         sel_txc;
  logic               sel_last;

  for (genvar i = 0; i < N_SRC; i++) begin : g_slice
    assign txd_arr[i] = src.src_txd[64*i +: 64];
    assign txc_arr[i] = src.src_txc[8*i +: 8];
  end

  // last_winner doubles as the granted index while in XFER
  assign sel_txd  = txd_arr[last_winner];
  assign sel_txc  = txc_arr[last_winner];
  assign sel_last = src.src_last[last_winner];
  assign busy     = (state != ST_IDLE);

  always_comb begin
    logic [IDX_W-1:0] cand;
    winner = last_winner;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = IDX_W'((int'(last_winner) + k) % N_SRC);
      if (!found && src.src_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    grant_onehot         = '0;
    grant_onehot[winner] = 1'b1;
  end

`ifdef XGMII_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(MAX_WORDS + 1);
  logic [WD_W-1:0] word_cnt;

  assign wd_hit = (word_cnt == WD_W'(MAX_WORDS));

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      word_cnt    <= '0;
      abort_count <= '0;
    end else begin
      if (grant_set) begin
        word_cnt <= '0;
      end else if (state == ST_XFER && !frame_abort) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (frame_abort && abort_count != 16'hFFFF) begin
        abort_count <= abort_count + 16'd1;
      end
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    grant_set   = 1'b0;
    frame_done  = 1'b0;
    frame_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          grant_set = 1'b1;
          state_d   = ST_XFER;
        end
      end
      ST_XFER: begin
        // watchdog wins over a late last: the word is already replaced by the error word
        if (wd_hit) begin
          frame_abort = 1'b1;
          state_d     = (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
        end else if (sel_last) begin
          frame_done = 1'b1;
          state_d    = (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
        end
      end
      ST_IFG: begin
        if (ifg_cnt == 4'(IFG_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      xgmii_txd     <= IDLE_TXD;
      xgmii_txc     <= 8'hFF;
      src.src_grant <= '0;
      last_winner   <= IDX_W'(N_SRC - 1);
      frame_count   <= '0;
      ifg_cnt       <= '0;
    end else begin
      if (state == ST_XFER) begin
        xgmii_txd <= frame_abort ? ERR_TXD : sel_txd;
        xgmii_txc <= frame_abort ? 8'hFF : sel_txc;
      end else begin
        xgmii_txd <= IDLE_TXD;
        xgmii_txc <= 8'hFF;
      end

      if (grant_set) begin
        src.src_grant <= grant_onehot;
        last_winner   <= winner;
      end else if (frame_done || frame_abort) begin
        src.src_grant <= '0;
      end

      if (frame_done) begin
        frame_count <= frame_count + 32'd1;
      end

      ifg_cnt <= (state == ST_IFG) ? ifg_cnt + 4'd1 : 4'd0;
    end
  end

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// tb/tb_xgmii_tx_arbiter.sv - directed scoreboard bench for xgmii_tx_arbiter (IFG=2 and IFG=0 instances)
module tb_xgmii_tx_arbiter;

  localparam logic [63:0] IDLE_W = {8{8'h07}};
  localparam logic [63:0] ERR_W  = {8{8'hFE}};

  typedef struct packed {
    logic [7:0]  c;
    logic [63:0] d;
  } word_t;

  logic          xgmii_clk = 1'b0;
  logic          sys_rst;
  logic [3:0]    req;
  logic [3:0]    last;
  logic [255:0]  txd_in;
  logic [31:0]   txc_in;
  logic          sel;

  logic [63:0]   txd_a, txd_b;
  logic [7:0]    txc_a, txc_b;
  logic          busy_a, busy_b;
  logic [31:0]   fc_a, fc_b;
`ifdef XGMII_ARB_WATCHDOG_EN
  logic [15:0]   ac_a, ac_b;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  word_t exp_q[$];

  always #5 xgmii_clk = ~xgmii_clk;

  xgmii_tx_arbiter_if #(.N_SRC(4)) bus_a ();
  xgmii_tx_arbiter_if #(.N_SRC(4)) bus_b ();

  assign bus_a.src_req  = req;
  assign bus_a.src_txd  = txd_in;
  assign bus_a.src_txc  = txc_in;
  assign bus_a.src_last = last;
  assign bus_b.src_req  = req;
  assign bus_b.src_txd  = txd_in;
  assign bus_b.src_txc  = txc_in;
  assign bus_b.src_last = last;

  xgmii_tx_arbiter #(.N_SRC(4), .IFG_CYCLES(2), .MAX_WORDS(8)) dut_a (
    .xgmii_clk   (xgmii_clk),
    .sys_rst     (sys_rst),
    .src         (bus_a),
    .xgmii_txd   (txd_a),
    .xgmii_txc   (txc_a),
    .busy        (busy_a),
    .frame_count (fc_a)
`ifdef XGMII_ARB_WATCHDOG_EN
    ,
    .abort_count (ac_a)
`endif
  );

  xgmii_tx_arbiter #(.N_SRC(4), .IFG_CYCLES(0), .MAX_WORDS(8)) dut_b (
    .xgmii_clk   (xgmii_clk),
    .sys_rst     (sys_rst),
    .src         (bus_b),
    .xgmii_txd   (txd_b),
    .xgmii_txc   (txc_b),
    .busy        (busy_b),
    .frame_count (fc_b)
`ifdef XGMII_ARB_WATCHDOG_EN
    ,
    .abort_count (ac_b)
`endif
  );

  wire [3:0]  g      = sel ? bus_b.src_grant : bus_a.src_grant;
  wire [63:0] lane_d = sel ? txd_b : txd_a;
  wire [7:0]  lane_c = sel ? txc_b : txc_a;
  wire        busy_s = sel ? busy_b : busy_a;
  wire [31:0] fc_s   = sel ? fc_b : fc_a;

  task automatic tick();
    @(posedge xgmii_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    word_t e;
    e = exp_q.pop_front();
    chk(tag, {lane_c, lane_d}, e);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    req     = '0;
    last    = '0;
    tick();
    tick();
    sys_rst = 1'b0;
    exp_q.delete();
  endtask

  // Every cycle spent waiting must show idle on the lane; the wait length is checked too.
  task automatic wait_grant(input logic [3:0] exp_g, input int exp_wait, input string tag);
    int n;
    n = 0;
    do begin
      exp_q.push_back({8'hFF, IDLE_W});
      tick();
      n++;
      pop_check({tag, "_idle"});
    end while (g == 4'b0 && n < 40);
    chk({tag, "_grant"}, 72'(g), 72'(exp_g));
    chk({tag, "_wait"}, 72'(n), 72'(exp_wait));
  endtask

  task automatic drive_words();
    for (int j = 0; j < 8; j++) txd_in[32*j +: 32] = $urandom;
    txc_in = $urandom;
  endtask

  task automatic send_frame(input int s, input int nw, input int drop_at, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    for (int w = 0; w < nw; w++) begin
      drive_words();
      last    = 4'($urandom) & ~oh;
      last[s] = (w == nw - 1);
      if (w == drop_at) req[s] = 1'b0;
      exp_q.push_back({txc_in[8*s +: 8], txd_in[64*s +: 64]});
      tick();
      pop_check({tag, "_word"});
      chk({tag, "_hold"}, 72'(g), 72'((w == nw - 1) ? 4'b0000 : oh));
    end
    last = '0;
  endtask

  initial begin
    sel    = 1'b0;
    txd_in = '0;
    txc_in = '0;
    do_reset();

    chk("rst_txd",  72'(txd_a), 72'(IDLE_W));
    chk("rst_txc",  72'(txc_a), 72'(8'hFF));
    chk("rst_gnt",  72'(g), 72'(4'b0000));
    chk("rst_busy", 72'(busy_a), 72'(1'b0));
    chk("rst_fc",   72'(fc_a), 72'(32'd0));
`ifdef XGMII_ARB_WATCHDOG_EN
    chk("rst_ac",   72'(ac_a), 72'(16'd0));
`endif

    // single source, 4-word frame, then the 2-cycle gap
    req = 4'b0100;
    wait_grant(4'b0100, 1, "t1");
    req = 4'b0000;
    send_frame(2, 4, -1, "t1");
    chk("t1_fc", 72'(fc_s), 72'(32'd1));
    chk("t1_busy_ifg", 72'(busy_s), 72'(1'b1));
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({8'hFF, IDLE_W});
      tick();
      pop_check("t1_gap");
    end
    chk("t1_busy_end", 72'(busy_s), 72'(1'b0));

    // all requesting: rotation 0,1,2,3,0 with 3-cycle grant spacing
    do_reset();
    req = 4'b1111;
    wait_grant(4'b0001, 1, "t2_g0");
    send_frame(0, 3, -1, "t2_f0");
    wait_grant(4'b0010, 3, "t2_g1");
    send_frame(1, 3, -1, "t2_f1");
    wait_grant(4'b0100, 3, "t2_g2");
    send_frame(2, 3, -1, "t2_f2");
    wait_grant(4'b1000, 3, "t2_g3");
    send_frame(3, 3, -1, "t2_f3");
    wait_grant(4'b0001, 3, "t2_g4");
    send_frame(0, 3, -1, "t2_f4");
    chk("t2_fc", 72'(fc_s), 72'(32'd5));

    // granted source drops its request mid-frame; grant held until last
    do_reset();
    req = 4'b0010;
    wait_grant(4'b0010, 1, "t6");
    send_frame(1, 6, 2, "t6");
    chk("t6_fc", 72'(fc_s), 72'(32'd1));

    // reset in the middle of a frame
    req = 4'b0001;
    wait_grant(4'b0001, 3, "t4");
    drive_words();
    exp_q.push_back({txc_in[7:0], txd_in[63:0]});
    tick();
    pop_check("t4_w0");
    drive_words();
    sys_rst = 1'b1;
    tick();
    chk("t4_txd",  72'(txd_a), 72'(IDLE_W));
    chk("t4_txc",  72'(txc_a), 72'(8'hFF));
    chk("t4_gnt",  72'(g), 72'(4'b0000));
    chk("t4_fc",   72'(fc_a), 72'(32'd0));
    chk("t4_busy", 72'(busy_a), 72'(1'b0));
    sys_rst = 1'b0;
    exp_q.delete();
    req = 4'b1111;
    wait_grant(4'b0001, 1, "t4_after");
    req = 4'b0000;
    send_frame(0, 5, -1, "t4_after");

    // zero inter-frame gap instance: one idle arbitration cycle between grants
    sel = 1'b1;
    do_reset();
    req = 4'b0011;
    wait_grant(4'b0001, 1, "t3_g0");
    send_frame(0, 3, -1, "t3_f0");
    wait_grant(4'b0010, 1, "t3_g1");
    send_frame(1, 3, -1, "t3_f1");
    chk("t3_fc", 72'(fc_s), 72'(32'd2));
    sel = 1'b0;

`ifdef XGMII_ARB_WATCHDOG_EN
    do_reset();
    req = 4'b0001;
    wait_grant(4'b0001, 1, "t5");
    for (int w = 0; w < 8; w++) begin
      drive_words();
      last = '0;
      exp_q.push_back({txc_in[7:0], txd_in[63:0]});
      tick();
      pop_check("t5_word");
      chk("t5_hold", 72'(g), 72'(4'b0001));
    end
    drive_words();
    exp_q.push_back({8'hFF, ERR_W});
    tick();
    pop_check("t5_err");
    chk("t5_gnt", 72'(g), 72'(4'b0000));
    chk("t5_ac",  72'(ac_a), 72'(16'd1));
    chk("t5_fc",  72'(fc_a), 72'(32'd0));
    req = 4'b0000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xgmii_tx_arbiter.md
Name: xgmii_tx_arbiter

Overview:
Round-robin scheduler that shares one 64-bit XGMII transmit lane among N_SRC frame sources.
- Grants one source at a time and muxes its words onto the lane.
- Outputs XGMII idle between frames and enforces a minimum inter-frame gap.
- Sits between user application frame generators and a network_path XGMII TX input, in the xgmii_clk (156.25 MHz) domain.

Parameters:
N_SRC, 4, number of requesting sources (2..8)
IFG_CYCLES, 2, forced idle cycles after each frame (0..15)
MAX_WORDS, 1200, watchdog limit on words per grant (used only with the optional feature)

Ports:
xgmii_clk  input  1  XGMII clock; all logic on its rising edge
sys_rst  input  1  synchronous, active-high reset
src_req  input  N_SRC  per-source frame request (level)
src_txd  input  64*N_SRC  per-source XGMII data; source i occupies bits [64i+63:64i]
src_txc  input  8*N_SRC  per-source XGMII control; source i occupies bits [8i+7:8i]
src_last  input  N_SRC  marks the final word of the granted source's frame
src_grant  output  N_SRC  one-hot grant, registered
xgmii_txd  output  64  lane data, registered
xgmii_txc  output  8  lane control, registered
busy  output  1  high in XFER or IFG
frame_count  output  32  frames completed, wraps at 2^32

Behaviour:
- Reset values: src_grant=0, xgmii_txd=64'h0707070707070707, xgmii_txc=8'hFF, busy=0, frame_count=0, state=IDLE, last_winner=N_SRC-1.
- Idle word is txd=64'h0707070707070707 with txc=8'hFF. It is driven in every cycle whose registered source is not XFER.
- IDLE:
  - If any src_req is high, pick the first requester searching from (last_winner+1) mod N_SRC upward, with wrap.
  - Next cycle: src_grant=onehot(winner), last_winner=winner, state=XFER.
  - If no request, stay in IDLE.
- XFER:
  - Each cycle, capture src_txd/src_txc of the granted source into the xgmii_txd/xgmii_txc registers. Output latency is 1 cycle.
  - No backpressure: the source must supply a valid word every granted cycle, starting in the first cycle grant is high.
  - src_req of the granted source is ignored in XFER. The frame ends only on src_last, or on watchdog abort.
  - When src_last[winner]=1 is sampled: that word is still captured. Next cycle: src_grant=0, frame_count+1, state=IFG (or IDLE if IFG_CYCLES=0).
  - src_last of non-granted sources is ignored.
- IFG: count IFG_CYCLES cycles, outputs idle, no arbitration, then go to IDLE.
  - Earliest next grant therefore rises IFG_CYCLES+1 cycles after src_grant falls.
- The arbiter does not check or modify XGMII framing. Sources emit Start/Terminate themselves.
- Same-cycle request and last: a request from another source while the current frame's last word is sampled is served only through the IFG→IDLE path. No back-to-back grant.
- sys_rst asserted mid-frame: next cycle all outputs take their reset values (idle, grant 0). A partial frame on the wire is truncated; the PHY treats it as a runt.
- Fairness: with all N_SRC requesting continuously, grants rotate 0,1,…,N_SRC-1,0,…

Optional Feature:
Macro XGMII_ARB_WATCHDOG_EN.
- Defined:
  - A word counter runs during XFER, cleared on each grant.
  - If MAX_WORDS words are captured without src_last, the next output word is forced to txd=64'hFEFEFEFEFEFEFEFE, txc=8'hFF (error) instead of source data.
  - src_grant drops the same cycle as that error word, state moves to IFG, and frame_count is not incremented.
  - Adds output abort_count (16-bit, saturating at 16'hFFFF, reset 0), incremented per abort.
- Undefined: no counter, no abort_count port; a source that never asserts src_last holds the lane indefinitely.

Test Plan:
1. Reset then src_req=4'b0100 → src_grant=4'b0100 one cycle later. Source words W0..W3 with last on W3 appear on xgmii_txd 1 cycle delayed. Then 2 idle cycles; frame_count=1.
2. src_req=4'b1111 held, 3-word frames each → grant order 0,1,2,3,0. Each grant rises 3 cycles after the previous one falls (IFG_CYCLES=2). Lane shows idle in gaps.
3. IFG_CYCLES=0, src_req=4'b0011 → grant 0 then grant 1. Exactly 1 idle cycle between them (IDLE arbitration cycle).
4. sys_rst pulse on the 2nd word of a 5-word frame → next cycle xgmii_txd=64'h0707…07, txc=8'hFF, src_grant=0, frame_count=0. After reset, source 0 wins first.
5. XGMII_ARB_WATCHDOG_EN with MAX_WORDS=8, source never asserts last → 8 data words, then one FE error word, grant drops, abort_count=1, frame_count unchanged.
6. Granted source drops src_req mid-frame, last on word 6 → all 6 words transmitted; grant held until last is sampled.
